// File: rtl/serpent_lt_pipe.sv
// Serpent linear transform, forward or inverse per block, with valid/ready flow control.
// Define SERPENT_LT_BYPASS_EN to add i_bypass, which passes blocks through unchanged.
module serpent_lt_pipe #(
    parameter int PIPE_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_inv,
`ifdef SERPENT_LT_BYPASS_EN
    input  logic        i_bypass,
`endif
    input  logic [31:0] i_word_0,
    input  logic [31:0] i_word_1,
    input  logic [31:0] i_word_2,
    input  logic [31:0] i_word_3,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_inv,
    output logic [31:0] o_word_0,
    output logic [31:0] o_word_1,
    output logic [31:0] o_word_2,
    output logic [31:0] o_word_3,
    output logic        o_busy
);

    typedef logic [3:0][31:0] blk_t;

    function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Forward transform split after the ROL1/ROL7 step.
    function automatic blk_t fwd_a(input blk_t x);
        logic [31:0] a, b, c, d;
        a = rol(x[0], 13);
        c = rol(x[2], 3);
        b = rol(x[1] ^ a ^ c, 1);
        d = rol(x[3] ^ c ^ (a << 3), 7);
        return {d, c, b, a};
    endfunction

    function automatic blk_t fwd_b(input blk_t x);
        logic [31:0] a, c;
        a = rol(x[0] ^ x[1] ^ x[3], 5);
        c = rol(x[2] ^ x[3] ^ (x[1] << 7), 22);
        return {x[3], c, x[1], a};
    endfunction

    // Inverse transform split after the ROR7/ROR1 step.
    function automatic blk_t inv_a(input blk_t x);
        logic [31:0] a, b, c, d;
        c = ror(x[2], 22) ^ x[3] ^ (x[1] << 7);
        a = ror(x[0], 5) ^ x[1] ^ x[3];
        d = ror(x[3], 7);
        b = ror(x[1], 1);
        return {d, c, b, a};
    endfunction

    function automatic blk_t inv_b(input blk_t x);
        logic [31:0] a, b, c, d;
        d = x[3] ^ x[2] ^ (x[0] << 3);
        b = x[1] ^ x[0] ^ x[2];
        c = ror(x[2], 3);
        a = ror(x[0], 13);
        return {d, c, b, a};
    endfunction

    function automatic blk_t half1(input blk_t x, input logic inv, input logic byp);
        if (byp) return x;
        return inv ? inv_a(x) : fwd_a(x);
    endfunction

    function automatic blk_t half2(input blk_t x, input logic inv, input logic byp);
        if (byp) return x;
        return inv ? inv_b(x) : fwd_b(x);
    endfunction

    blk_t din;
    blk_t dout;
    logic byp_in;

    assign din = {i_word_3, i_word_2, i_word_1, i_word_0};
`ifdef SERPENT_LT_BYPASS_EN
    assign byp_in = i_bypass;
`else
    assign byp_in = 1'b0;
`endif

    assign o_word_0 = dout[0];
    assign o_word_1 = dout[1];
    assign o_word_2 = dout[2];
    assign o_word_3 = dout[3];

    if (PIPE_STAGES == 2) begin : g_two
        logic v1, inv1, byp1, v2, inv2;
        blk_t d1, d2;
        logic rdy1, rdy2;

        assign rdy2 = !v2 | i_ready;
        assign rdy1 = !v1 | rdy2;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v1   <= 1'b0;
                inv1 <= 1'b0;
                byp1 <= 1'b0;
                d1   <= '0;
                v2   <= 1'b0;
                inv2 <= 1'b0;
                d2   <= '0;
            end else begin
                if (rdy1) begin
                    v1 <= i_valid;
                    if (i_valid) begin
                        d1   <= half1(din, i_inv, byp_in);
                        inv1 <= i_inv;
                        byp1 <= byp_in;
                    end
                end
                // Stage 2 fills its bubble regardless of i_ready.
                if (rdy2) begin
                    v2 <= v1;
                    if (v1) begin
                        d2   <= half2(d1, inv1, byp1);
                        inv2 <= inv1;
                    end
                end
            end
        end

        assign o_ready = rdy1;
        assign o_valid = v2;
        assign o_inv   = inv2;
        assign o_busy  = v1 | v2;
        assign dout    = d2;
    end else if (PIPE_STAGES == 1) begin : g_one
        logic v, inv;
        blk_t d;
        logic rdy;

        assign rdy = !v | i_ready;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                v   <= 1'b0;
                inv <= 1'b0;
                d   <= '0;
            end else if (rdy) begin
                v <= i_valid;
                if (i_valid) begin
                    d   <= half2(half1(din, i_inv, byp_in), i_inv, byp_in);
                    inv <= i_inv;
                end
            end
        end

        assign o_ready = rdy;
        assign o_valid = v;
        assign o_inv   = inv;
        assign o_busy  = v;
        assign dout    = d;
    end else begin : g_bad
        $error("serpent_lt_pipe: PIPE_STAGES must be 1 or 2");
    end

endmodule

// File: tb/tb_serpent_lt_pipe.sv
// Scoreboard bench: a 2-stage instance feeding a 1-stage instance in the opposite mode.
// Expected results come from a whole-block reference model of the transform.
module tb_serpent_lt_pipe;

    typedef logic [3:0][31:0] blk_t;
    typedef struct {
        blk_t w;
        logic inv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_valid = 1'b0;
    logic a_inv = 1'b0;
    logic a_byp = 1'b0;
    blk_t a_in = '0;
    logic a_ready, a_ovalid, a_oinv, a_busy;
    blk_t a_out;
    logic b_ready, b_ovalid, b_oinv, b_busy, b_inv;
    blk_t b_out;
    logic sink_ready = 1'b1;
    logic rand_sink = 1'b0;

    int errors = 0;
    int checks = 0;
    exp_t qa[$];
    exp_t qb[$];

    assign b_inv = !a_oinv;

    always #5 clk = ~clk;

    serpent_lt_pipe #(.PIPE_STAGES(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(a_valid), .o_ready(a_ready), .i_inv(a_inv),
`ifdef SERPENT_LT_BYPASS_EN
        .i_bypass(a_byp),
`endif
        .i_word_0(a_in[0]), .i_word_1(a_in[1]),
        .i_word_2(a_in[2]), .i_word_3(a_in[3]),
        .o_valid(a_ovalid), .i_ready(b_ready), .o_inv(a_oinv),
        .o_word_0(a_out[0]), .o_word_1(a_out[1]),
        .o_word_2(a_out[2]), .o_word_3(a_out[3]),
        .o_busy(a_busy)
    );

    serpent_lt_pipe #(.PIPE_STAGES(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(a_ovalid), .o_ready(b_ready), .i_inv(b_inv),
`ifdef SERPENT_LT_BYPASS_EN
        .i_bypass(1'b0),
`endif
        .i_word_0(a_out[0]), .i_word_1(a_out[1]),
        .i_word_2(a_out[2]), .i_word_3(a_out[3]),
        .o_valid(b_ovalid), .i_ready(sink_ready), .o_inv(b_oinv),
        .o_word_0(b_out[0]), .o_word_1(b_out[1]),
        .o_word_2(b_out[2]), .o_word_3(b_out[3]),
        .o_busy(b_busy)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic blk_t lt_ref(input blk_t x, input logic inv);
        logic [31:0] x0, x1, x2, x3;
        x0 = x[0]; x1 = x[1]; x2 = x[2]; x3 = x[3];
        if (!inv) begin
            x0 = rl(x0, 13); x2 = rl(x2, 3);
            x1 ^= x0 ^ x2; x3 ^= x2 ^ (x0 << 3);
            x1 = rl(x1, 1); x3 = rl(x3, 7);
            x0 ^= x1 ^ x3; x2 ^= x3 ^ (x1 << 7);
            x0 = rl(x0, 5); x2 = rl(x2, 22);
        end else begin
            x2 = rl(x2, 32 - 22); x0 = rl(x0, 32 - 5);
            x2 ^= x3 ^ (x1 << 7); x0 ^= x1 ^ x3;
            x3 = rl(x3, 32 - 7); x1 = rl(x1, 32 - 1);
            x3 ^= x2 ^ (x0 << 3); x1 ^= x0 ^ x2;
            x2 = rl(x2, 32 - 3); x0 = rl(x0, 32 - 13);
        end
        return {x3, x2, x1, x0};
    endfunction

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expectation not met at time %0t", name, $time);
    endtask

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && a_ovalid && b_ready) begin
            if (qa.size() == 0) fail("a_extra_output");
            else begin
                e = qa.pop_front();
                chk("a_out", {3'b0, a_oinv, a_out}, {3'b0, e.inv, e.w});
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && b_ovalid && sink_ready) begin
            if (qb.size() == 0) fail("b_extra_output");
            else begin
                e = qb.pop_front();
                chk("b_out", {3'b0, b_oinv, b_out}, {3'b0, e.inv, e.w});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_sink) sink_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input blk_t w, input logic inv, input logic byp,
                        input blk_t ea, input blk_t eb, output int waits);
        a_in = w; a_inv = inv; a_byp = byp; a_valid = 1'b1; waits = 0;
        forever begin
            @(negedge clk);
            waits++;
            if (a_ready) break;
            if (waits > 500) begin
                fail("send_timeout");
                break;
            end
        end
        if (a_ready) begin
            qa.push_back('{ea, inv});
            qb.push_back('{eb, !inv});
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic send_rand(input logic inv, input logic byp, output int waits);
        blk_t w;
        w = {$urandom, $urandom, $urandom, $urandom};
        if (byp) send(w, inv, byp, w, lt_ref(w, !inv), waits);
        else send(w, inv, byp, lt_ref(w, inv), w, waits);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (qa.size() != 0 || qb.size() != 0) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic fill3();
        int wt;
        for (int i = 0; i < 3; i++) send_rand(i[0], 1'b0, wt);
    endtask

    initial begin
        blk_t one, fw, dbf;
        int wt, total;
        one = {32'h0, 32'h0, 32'h0, 32'h1};
        fw = {32'h0080_0000, 32'h0000_2800, 32'h0000_4000, 32'h100C_0000};
        dbf = {32'h3, 32'h2, 32'h1, 32'hDEAD_BEEF};

        repeat (3) @(negedge clk);
        chk("reset_a", {a_ovalid, a_busy, a_oinv, a_ready, a_out}, {4'b0001, 128'h0});
        chk("reset_b", {b_ovalid, b_busy, b_oinv, b_ready, b_out}, {4'b0001, 128'h0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        send(one, 1'b0, 1'b0, fw, one, wt);
        @(negedge clk);
        chk("lat_a_cycle1", {131'h0, a_ovalid}, 132'h0);
        @(negedge clk);
        chk("lat_a_cycle2", {130'h0, a_ovalid, b_ovalid}, 132'h2);
        @(negedge clk);
        chk("lat_b_cycle1", {131'h0, b_ovalid}, 132'h1);
        drain();

        send(fw, 1'b1, 1'b0, one, fw, wt);
        drain();

`ifdef SERPENT_LT_BYPASS_EN
        send(dbf, 1'b1, 1'b1, dbf, lt_ref(dbf, 1'b0), wt);
        @(negedge clk);
        chk("byp_lat_c1", {131'h0, a_ovalid}, 132'h0);
        @(negedge clk);
        chk("byp_lat_c2", {131'h0, a_ovalid}, 132'h1);
        drain();
        send(dbf, 1'b0, 1'b1, dbf, lt_ref(dbf, 1'b1), wt);
        drain();
`else
        send(dbf, 1'b0, 1'b0, lt_ref(dbf, 1'b0), dbf, wt);
        drain();
`endif

        total = 0;
        for (int i = 0; i < 1000; i++) begin
            send_rand(i[0], 1'b0, wt);
            total += wt;
        end
        chk("throughput_cycles", 132'(total), 132'd1000);
        drain();

        sink_ready = 1'b0;
        fill3();
        @(negedge clk);
        chk("bp_full", {129'h0, a_ready, a_busy, b_ovalid}, 132'h3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {3'b0, a_ovalid, a_out}, {3'b0, 1'b1, qa[0].w});
            chk("bp_ready", {131'h0, a_ready}, 132'h0);
        end
        @(posedge clk);
        #1 sink_ready = 1'b1;
        drain();

        rand_sink = 1'b1;
        for (int i = 0; i < 300; i++) begin
`ifdef SERPENT_LT_BYPASS_EN
            send_rand(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), wt);
`else
            send_rand(1'($urandom_range(0, 1)), 1'b0, wt);
`endif
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_sink = 1'b0;
        sink_ready = 1'b1;
        drain();

        sink_ready = 1'b0;
        fill3();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_a", {a_ovalid, a_busy, a_oinv, a_ready, a_out}, {4'b0001, 128'h0});
        chk("midreset_b", {b_ovalid, b_busy, b_oinv, b_ready, b_out}, {4'b0001, 128'h0});
        qa.delete();
        qb.delete();
        sink_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(one, 1'b0, 1'b0, fw, one, wt);
        drain();
        @(negedge clk);
        chk("idle_busy", {130'h0, a_busy, b_busy}, 132'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
